// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, constants and bus-slice helper for the register file
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;
  localparam int RF_MAX_BUS  = 256;
  localparam int RF_MAX_W    = 64;

  // Returns field k of width w from a packed multi-port bus, zero-extended.
  function automatic logic [RF_MAX_W-1:0] rf_slice(input logic [RF_MAX_BUS-1:0] bus,
                                                   input int k, input int w);
    logic [RF_MAX_BUS-1:0] sh;
    logic [RF_MAX_W-1:0]   mask;
    sh   = bus >> (k * w);
    mask = '0;
    for (int i = 0; i < RF_MAX_W; i++) begin
      if (i < w) mask[i] = 1'b1;
    end
    return sh[RF_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/rf_sb_bits.sv
// rtl/rf_sb_bits.sv - per-register busy scoreboard with issue-priority set/clear
module rf_sb_bits
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        if (iss_en && iss_addr == ADDR_W'(r))
          busy[r] <= 1'b1;
        else if (wr_en && wr_addr == ADDR_W'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a = ADDR_W'(rf_slice(RF_MAX_BUS'(rd_addr), k, ADDR_W));
    // A register retiring this cycle is served by the bypass, so it is not a hazard.
    assign rd_busy[k] = busy[a] && !(wr_en && wr_addr == a);
  end

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass and busy scoreboard; RF_PARITY_EN adds parity
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic [ADDR_W-1:0]     dbg_sel,
  output logic [DATA_W-1:0]     dbg_data,
`ifdef RF_PARITY_EN
  output logic [NRD-1:0]        par_err,
`endif
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef RF_PARITY_EN
  logic [DEPTH-1:0]  par_bits;
`endif
  logic              wr_act;

  // Bypass is suppressed while reset is held so every read port reports 0.
  assign wr_act = wr_en && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (wr_en && wr_addr != ZERO_A) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef RF_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_bits <= '0;
    else if (wr_en && wr_addr != ZERO_A)
      par_bits[wr_addr] <= ^wr_data;
  end
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp;
    logic [DATA_W-1:0] w;

    assign a   = ADDR_W'(rf_slice(RF_MAX_BUS'(rd_addr), k, ADDR_W));
    assign byp = wr_act && (wr_addr == a);

    always_comb begin
      w = '0;
      if (a == ZERO_A)
        w = '0;
      else if (byp)
        w = wr_data;
      else
        w = mem[a];
    end

    assign rd_data[k*DATA_W +: DATA_W] = w;
`ifdef RF_PARITY_EN
    assign par_err[k] = (a != ZERO_A) && !byp && ((^mem[a]) != par_bits[a]);
`endif
  end

  assign dbg_data = (dbg_sel == ZERO_A) ? '0 : mem[dbg_sel];

  rf_sb_bits #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb; parity checks under RF_PARITY_EN
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  localparam int S_RD0  = 0;
  localparam int S_RD1  = 1;
  localparam int S_DBG  = 2;
  localparam int S_RDB  = 3;
  localparam int S_BVEC = 4;
  localparam int S_PAR  = 5;

  localparam int WDOG_CYCLES = 2000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW-1:0]       dbg_sel;
  logic [DW-1:0]       dbg_data;
  logic [DEPTH-1:0]    busy_vec;
`ifdef RF_PARITY_EN
  logic [NRD-1:0]      par_err;
`endif

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
`ifdef RF_PARITY_EN
    .par_err  (par_err),
`endif
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [63:0] mon_act;
  int          n_pass  = 0;
  int          n_total = 0;
  logic        done    = 1'b0;

  function automatic logic [63:0] observe(input int sel);
    logic [63:0] v;
    v = '0;
    case (sel)
      S_RD0:  v = 64'(rd_data[0 +: DW]);
      S_RD1:  v = 64'(rd_data[DW +: DW]);
      S_DBG:  v = 64'(dbg_data);
      S_RDB:  v = 64'(rd_busy);
      S_BVEC: v = 64'(busy_vec);
`ifdef RF_PARITY_EN
      S_PAR:  v = 64'(par_err);
`endif
      default: v = '1;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = observe(mon_e.sel);
      n_total++;
      if (mon_act === mon_e.exp)
        n_pass++;
      else
        $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.exp);
    end
  end

  task automatic check_now(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, expected %h", n, act, exp);
  endtask

  initial begin
    repeat (WDOG_CYCLES) @(posedge clk);
    if (!done) begin
      $display("FAIL watchdog: test did not finish within %0d cycles", WDOG_CYCLES);
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $finish;
    end
  end

  task automatic push(input string n, input int sel, input logic [63:0] v);
    q.push_back('{name: n, sel: sel, exp: v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    dbg_sel  = '0;

    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0001; set_rd(5'd3, 5'd3); dbg_sel = 5'd3;
    push("rst_held_rd0", S_RD0, 64'h0);
    push("rst_held_dbg", S_DBG, 64'h0);
    push("rst_held_bvec", S_BVEC, 64'h0);
    #1;
    check_now("rst_held_rdb_now", 64'(rd_busy), 64'h0);
    step();
    idle();
    rst_n = 1'b1;
    #1;
    check_now("rst_release_bvec_now", 64'(busy_vec), 64'h0);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a[AW-1:0], a[AW-1:0]);
      dbg_sel = a[AW-1:0];
      push($sformatf("rst_rd0_r%0d", a), S_RD0, 64'h0);
      push($sformatf("rst_rd1_r%0d", a), S_RD1, 64'h0);
      push($sformatf("rst_dbg_r%0d", a), S_DBG, 64'h0);
      if (a == 0) push("rst_bvec", S_BVEC, 64'h0);
      step();
    end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    idle(); set_rd(5'd5, 5'd0); dbg_sel = 5'd5;
    push("wr_r5_rd0", S_RD0, 64'hDEADBEEF);
    push("wr_r5_dbg", S_DBG, 64'hDEADBEEF);
    step();

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h00001234; set_rd(5'd0, 5'd0); dbg_sel = 5'd0;
    push("wr_r0_byp_rd0", S_RD0, 64'h0);
    push("wr_r0_byp_rd1", S_RD1, 64'h0);
    step();
    idle();
    push("wr_r0_rd0", S_RD0, 64'h0);
    push("wr_r0_rd1", S_RD1, 64'h0);
    push("wr_r0_dbg", S_DBG, 64'h0);
    step();

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; set_rd(5'd5, 5'd7); dbg_sel = 5'd7;
    push("byp_rd1", S_RD1, 64'hA5A5A5A5);
    push("byp_rd0_other", S_RD0, 64'hDEADBEEF);
    push("byp_dbg_old", S_DBG, 64'h0);
    step();
    idle();
    push("byp_dbg_after", S_DBG, 64'hA5A5A5A5);
    step();

    iss_en = 1'b1; iss_addr = 5'd9; set_rd(5'd9, 5'd5);
    push("iss_same_cycle", S_RDB, 64'h0);
    step();
    idle();
    push("iss_busy", S_RDB, 64'h1);
    push("iss_bvec", S_BVEC, 64'h200);
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099; set_rd(5'd9, 5'd9);
    push("wb_cycle_busy", S_RDB, 64'h0);
    push("wb_cycle_rd0", S_RD0, 64'h99);
    push("wb_cycle_bvec", S_BVEC, 64'h200);
    step();
    idle();
    push("wb_after_busy", S_RDB, 64'h0);
    push("wb_after_bvec", S_BVEC, 64'h0);
    step();

    iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00001111;
    step();
    idle();
    push("iss_wins_bvec", S_BVEC, 64'h200);
    push("iss_wins_rd0", S_RD0, 64'h1111);
    push("iss_wins_busy", S_RDB, 64'h3);
    step();
    iss_en = 1'b1; iss_addr = 5'd0;
    step();
    iss_en = 1'b1; iss_addr = 5'd9;
    step();
    idle();
    push("iss_r0_and_rebusy", S_BVEC, 64'h200);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h000000AB;
    step();
    idle(); set_rd(5'd10, 5'd9);
    push("wb_nonbusy_bvec", S_BVEC, 64'h200);
    push("wb_nonbusy_rd0", S_RD0, 64'hAB);
    push("wb_nonbusy_rdb", S_RDB, 64'h2);
    step();

    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000055; iss_en = 1'b1; iss_addr = 5'd3;
    step();
    idle(); set_rd(5'd3, 5'd9); dbg_sel = 5'd3;
    push("pre_rst_rd0", S_RD0, 64'h55);
    push("pre_rst_bvec", S_BVEC, 64'h208);
    step();
    #2;
    rst_n = 1'b0;
    push("async_rst_rd0", S_RD0, 64'h0);
    push("async_rst_rd1", S_RD1, 64'h0);
    push("async_rst_dbg", S_DBG, 64'h0);
    push("async_rst_rdb", S_RDB, 64'h0);
    push("async_rst_bvec", S_BVEC, 64'h0);
    #1;
    check_now("async_rst_bvec_now", 64'(busy_vec), 64'h0);
    step();
    rst_n = 1'b1;
    step();

`ifdef RF_PARITY_EN
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h000000FF;
    step();
    idle(); set_rd(5'd4, 5'd0);
    push("par_clean", S_PAR, 64'h0);
    step();
    force dut.par_bits = 32'h00000010;
    #1;
    push("par_flip", S_PAR, 64'h1);
    step();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h000000FF;
    push("par_bypass", S_PAR, 64'h0);
    step();
    idle();
    release dut.par_bits;
    step();
`endif

    repeat (2) step();
    check_now("queue_drained", 64'(q.size()), 64'h0);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
